// File: rtl/fpu_wb_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fpu_wb_sequencer
// Brief    : Wishbone classic initiator that runs one FPU command through the
//            FPU register map and returns the result and exception flags.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_wb_sequencer #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter logic [7:0]  OFF_OPA     = 8'h00,
    parameter logic [7:0]  OFF_OPB     = 8'h04,
    parameter logic [7:0]  OFF_OPC     = 8'h08,
    parameter logic [7:0]  OFF_FRM     = 8'h0C,
    parameter logic [7:0]  OFF_OPV     = 8'h10,
    parameter logic [7:0]  OFF_RES     = 8'h14,
    parameter logic [7:0]  OFF_EXC     = 8'h18,
    parameter int          FAST_WAIT   = 2,
    parameter int          SLOW_WAIT   = 40,
    parameter int          ACK_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_opa,
    input  logic [31:0] cmd_opb,
    input  logic [31:0] cmd_opc,
    input  logic [12:0] cmd_opv,
    input  logic [2:0]  cmd_frm,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [4:0]  rsp_exc,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);
    localparam logic [3:0] c_st_idle   = 4'd0;
    localparam logic [3:0] c_st_wr_a   = 4'd1;
    localparam logic [3:0] c_st_wr_b   = 4'd2;
    localparam logic [3:0] c_st_wr_c   = 4'd3;
    localparam logic [3:0] c_st_wr_frm = 4'd4;
    localparam logic [3:0] c_st_wr_opv = 4'd5;
    localparam logic [3:0] c_st_wait   = 4'd6;
    localparam logic [3:0] c_st_rd_res = 4'd7;
    localparam logic [3:0] c_st_rd_exc = 4'd8;
    localparam logic [3:0] c_st_resp   = 4'd9;

    localparam logic [15:0] c_fast_lim = 16'(FAST_WAIT - 1);
    localparam logic [15:0] c_slow_lim = 16'(SLOW_WAIT - 1);
    localparam logic [15:0] c_to_lim   = 16'(ACK_TIMEOUT - 1);

    logic [3:0]  r_state;
    logic        r_gap;
    logic [15:0] r_wait_cnt;
    logic [15:0] r_to_cnt;
    logic [31:0] r_opa;
    logic [31:0] r_opb;
    logic [31:0] r_opc;
    logic [12:0] r_opv;
    logic [2:0]  r_frm;

    logic [10:0] w_valid_in;
    logic        w_cmd_ok;
    logic        w_ack;
    logic [15:0] w_wait_lim;
    logic [7:0]  w_off;
    logic        w_we;
    logic [31:0] w_wdat;
    logic [3:0]  w_next;

    assign cmd_ready = (r_state == c_st_idle);

    always_comb begin
        w_valid_in = cmd_opv[12:2];
        w_cmd_ok   = (w_valid_in != 11'd0) && ((w_valid_in & (w_valid_in - 11'd1)) == 11'd0);
        // valid_in[9]/[10] (div/sqrt) take the long wait
        w_wait_lim = (r_opv[11] || r_opv[12]) ? c_slow_lim : c_fast_lim;
        w_ack      = wbm_stb_o && wbm_ack_i;
        w_off      = 8'h00;
        w_we       = 1'b0;
        w_wdat     = 32'h0;
        w_next     = c_st_idle;
        case (r_state)
            c_st_wr_a: begin
                w_off = OFF_OPA; w_we = 1'b1; w_wdat = r_opa; w_next = c_st_wr_b;
            end
            c_st_wr_b: begin
                w_off = OFF_OPB; w_we = 1'b1; w_wdat = r_opb;
                w_next = r_opv[10] ? c_st_wr_c : c_st_wr_frm;
            end
            c_st_wr_c: begin
                w_off = OFF_OPC; w_we = 1'b1; w_wdat = r_opc; w_next = c_st_wr_frm;
            end
            c_st_wr_frm: begin
                w_off = OFF_FRM; w_we = 1'b1; w_wdat = {29'h0, r_frm}; w_next = c_st_wr_opv;
            end
            c_st_wr_opv: begin
                w_off = OFF_OPV; w_we = 1'b1; w_wdat = {19'h0, r_opv}; w_next = c_st_wait;
            end
            c_st_rd_res: begin
                w_off = OFF_RES; w_next = c_st_rd_exc;
            end
            c_st_rd_exc: begin
                w_off = OFF_EXC; w_next = c_st_resp;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_state    <= c_st_idle;
            r_gap      <= 1'b0;
            r_wait_cnt <= 16'h0;
            r_to_cnt   <= 16'h0;
            r_opa      <= 32'h0;
            r_opb      <= 32'h0;
            r_opc      <= 32'h0;
            r_opv      <= 13'h0;
            r_frm      <= 3'h0;
            rsp_valid  <= 1'b0;
            rsp_result <= 32'h0;
            rsp_exc    <= 5'h0;
            rsp_err    <= 1'b0;
            wbm_cyc_o  <= 1'b0;
            wbm_stb_o  <= 1'b0;
            wbm_we_o   <= 1'b0;
            wbm_sel_o  <= 4'h0;
            wbm_adr_o  <= 32'h0;
            wbm_dat_o  <= 32'h0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (cmd_valid) begin
                        r_opa      <= cmd_opa;
                        r_opb      <= cmd_opb;
                        r_opc      <= cmd_opc;
                        r_opv      <= cmd_opv;
                        r_frm      <= cmd_frm;
                        rsp_result <= 32'h0;
                        rsp_exc    <= 5'h0;
                        r_gap      <= 1'b0;
                        if (w_cmd_ok) begin
                            r_state   <= c_st_wr_a;
                            rsp_err   <= 1'b0;
                            r_to_cnt  <= 16'h0;
                            wbm_cyc_o <= 1'b1;
                            wbm_stb_o <= 1'b1;
                            wbm_we_o  <= 1'b1;
                            wbm_sel_o <= 4'hF;
                            wbm_adr_o <= BASE_ADDR + {24'h0, OFF_OPA};
                            wbm_dat_o <= cmd_opa;
                        end else begin
                            r_state   <= c_st_resp;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end
                    end
                end
                c_st_wait: begin
                    if (r_wait_cnt == w_wait_lim) begin
                        r_state   <= c_st_rd_res;
                        r_to_cnt  <= 16'h0;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_we_o  <= 1'b0;
                        wbm_sel_o <= 4'hF;
                        wbm_adr_o <= BASE_ADDR + {24'h0, OFF_RES};
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 16'd1;
                    end
                end
                c_st_resp: begin
                    if (r_gap) begin
                        r_gap     <= 1'b0;
                        rsp_valid <= 1'b1;
                    end else if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= c_st_idle;
                    end
                end
                default: begin
                    // r_gap marks the idle cycle between two strobes
                    if (r_gap) begin
                        r_gap     <= 1'b0;
                        r_to_cnt  <= 16'h0;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_we_o  <= w_we;
                        wbm_sel_o <= 4'hF;
                        wbm_adr_o <= BASE_ADDR + {24'h0, w_off};
                        wbm_dat_o <= w_wdat;
                    end else if (w_ack) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_sel_o <= 4'h0;
                        if (r_state == c_st_rd_res) rsp_result <= wbm_dat_i;
                        if (r_state == c_st_rd_exc) rsp_exc <= wbm_dat_i[4:0];
                        r_state <= w_next;
                        if (w_next == c_st_wait) r_wait_cnt <= 16'h0;
                        else                     r_gap      <= 1'b1;
                    end else if (r_to_cnt == c_to_lim) begin
                        wbm_cyc_o  <= 1'b0;
                        wbm_stb_o  <= 1'b0;
                        wbm_sel_o  <= 4'h0;
                        r_state    <= c_st_resp;
                        rsp_valid  <= 1'b1;
                        rsp_err    <= 1'b1;
                        rsp_result <= 32'h0;
                        rsp_exc    <= 5'h0;
                    end else begin
                        r_to_cnt <= r_to_cnt + 16'd1;
                    end
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fpu_wb_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_wb_sequencer
// Brief    : Randomized self-checking bench with a Wishbone FPU slave model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_wb_sequencer;
    localparam logic [31:0] c_base = 32'h3000_0000;
    localparam int c_fast = 2;
    localparam int c_slow = 40;
    localparam int c_to   = 64;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_opa = 32'h0, cmd_opb = 32'h0, cmd_opc = 32'h0;
    logic [12:0] cmd_opv = 13'h0;
    logic [2:0]  cmd_frm = 3'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic [4:0]  rsp_exc;
    logic        rsp_err;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [31:0] wbm_dat_i = 32'h0;
    logic        wbm_ack_i = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc_n = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    fpu_wb_sequencer u_dut (
        .clk(clk), .rst_l(rst_l),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opa(cmd_opa), .cmd_opb(cmd_opb), .cmd_opc(cmd_opc),
        .cmd_opv(cmd_opv), .cmd_frm(cmd_frm),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_exc(rsp_exc), .rsp_err(rsp_err),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // FPU register slave: random ack delay, optional spurious acks, optional dead address
    logic [31:0] s_res_val = 32'h0, s_exc_val = 32'h0, s_na_adr = 32'h0;
    int          s_dmax = 0;
    bit          s_spur = 1'b0, s_na_en = 1'b0;
    int          s_wcnt = 0, s_delay = 0, s_run = 0, s_last_run = 0;
    int          s_stb_total = 0, s_b2b = 0, s_sel_bad = 0;
    int          s_t_opv_ack = 0, s_t_res_stb = 0;
    bit          s_prev_ack = 1'b0;
    logic [31:0] q_adr[$];
    logic [31:0] q_dat[$];
    logic        q_we[$];

    always @(negedge clk) begin
        if (wbm_cyc_o && wbm_stb_o) begin
            s_stb_total++;
            if (s_prev_ack) s_b2b++;
            if (wbm_sel_o != 4'hF) s_sel_bad++;
            if (s_run == 0 && wbm_adr_o == c_base + 32'h14) s_t_res_stb = cyc_n;
            s_run++;
            if (!(s_na_en && wbm_adr_o == s_na_adr) && s_wcnt >= s_delay) begin
                wbm_ack_i = 1'b1;
                if (wbm_adr_o == c_base + 32'h14)      wbm_dat_i = s_res_val;
                else if (wbm_adr_o == c_base + 32'h18) wbm_dat_i = s_exc_val;
                else                                   wbm_dat_i = $urandom;
                q_adr.push_back(wbm_adr_o);
                q_we.push_back(wbm_we_o);
                q_dat.push_back(wbm_we_o ? wbm_dat_o : 32'h0);
                if (wbm_we_o && wbm_adr_o == c_base + 32'h10) s_t_opv_ack = cyc_n;
                s_prev_ack = 1'b1;
            end else begin
                wbm_ack_i  = 1'b0;
                s_wcnt++;
                s_prev_ack = 1'b0;
            end
        end else begin
            if (s_run != 0) s_last_run = s_run;
            s_run      = 0;
            s_wcnt     = 0;
            s_delay    = int'($urandom_range(0, s_dmax));
            s_prev_ack = 1'b0;
            wbm_ack_i  = s_spur ? 1'($urandom_range(0, 1)) : 1'b0;
            wbm_dat_i  = $urandom;
        end
    end

    task automatic run_cmd(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                           input logic [12:0] opv, input logic [2:0] frm,
                           input logic [31:0] resv, input logic [31:0] excv,
                           input int dmax, input bit spur, input int hold);
        logic [31:0] e_adr[$];
        logic [31:0] e_dat[$];
        logic        e_we[$];
        logic [10:0] vin;
        logic [31:0] h_res;
        logic [4:0]  h_exc;
        logic        h_err;
        bit          ok;
        int          base, stb0, t_acc, t_rsp, k, nx, na, wexp, bp_bad;

        // Expected bus program and response from the command alone
        vin  = opv[12:2];
        ok   = ($countones(vin) == 1);
        wexp = (vin[9] || vin[10]) ? c_slow : c_fast;
        if (ok) begin
            e_adr.push_back(c_base + 32'h00); e_we.push_back(1'b1); e_dat.push_back(a);
            e_adr.push_back(c_base + 32'h04); e_we.push_back(1'b1); e_dat.push_back(b);
            if (vin[8]) begin
                e_adr.push_back(c_base + 32'h08); e_we.push_back(1'b1); e_dat.push_back(c);
            end
            e_adr.push_back(c_base + 32'h0C); e_we.push_back(1'b1); e_dat.push_back({29'h0, frm});
            e_adr.push_back(c_base + 32'h10); e_we.push_back(1'b1); e_dat.push_back({19'h0, opv});
            e_adr.push_back(c_base + 32'h14); e_we.push_back(1'b0); e_dat.push_back(32'h0);
            e_adr.push_back(c_base + 32'h18); e_we.push_back(1'b0); e_dat.push_back(32'h0);
        end
        nx = e_adr.size();

        s_res_val = resv; s_exc_val = excv; s_dmax = dmax; s_spur = spur;
        @(negedge clk);
        base = q_adr.size();
        stb0 = s_stb_total;
        cmd_valid = 1'b1; cmd_opa = a; cmd_opb = b; cmd_opc = c; cmd_opv = opv; cmd_frm = frm;
        k = 0;
        while (!cmd_ready && k < 300) begin @(negedge clk); k++; end
        check_val("accept", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1 t_acc = cyc_n;
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 0;
        while (!rsp_valid && k < 400) begin @(negedge clk); k++; end
        t_rsp = cyc_n;
        check_val("rsp_seen", 32'(rsp_valid), 32'd1);
        if (ok && dmax == 0)
            check_val("latency", 32'(t_rsp - t_acc + 2), 32'(2 * nx + wexp + 1));
        if (!ok)
            check_val("bad_lat_le2", 32'(t_rsp - t_acc + 1 <= 2), 32'd1);

        h_res = rsp_result; h_exc = rsp_exc; h_err = rsp_err;
        if (hold > 0) begin
            bp_bad = 0;
            cmd_valid = 1'b1; cmd_opv = 13'h0;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (!rsp_valid || rsp_result != h_res || rsp_exc != h_exc || rsp_err != h_err) bp_bad++;
                if (cmd_ready) bp_bad++;
            end
            check_val("bp_stable", 32'(bp_bad), 32'd0);
            cmd_valid = 1'b0;
        end
        check_val("rsp_err", 32'(h_err), 32'(!ok));
        check_val("rsp_result", h_res, ok ? resv : 32'h0);
        check_val("rsp_exc", 32'(h_exc), ok ? {27'h0, excv[4:0]} : 32'h0);

        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_val("rsp_drop", 32'(rsp_valid), 32'd0);
        check_val("idle_ready", 32'(cmd_ready), 32'd1);
        #1;
        na = q_adr.size() - base;
        check_val("xfer_count", 32'(na), 32'(nx));
        for (int i = 0; i < nx && i < na; i++) begin
            check_val("xfer_adr", q_adr[base + i], e_adr[i]);
            check_val("xfer_we", 32'(q_we[base + i]), 32'(e_we[i]));
            if (e_we[i]) check_val("xfer_dat", q_dat[base + i], e_dat[i]);
        end
        if (ok) check_val("wait_cycles", 32'(s_t_res_stb - s_t_opv_ack - 1), 32'(wexp));
        else    check_val("bad_no_stb", 32'(s_stb_total - stb0), 32'd0);
    endtask

    // Bus stalls on a dead address; exercise either timeout or mid-strobe reset
    task automatic run_stall(input logic [31:0] dead_adr, input bit do_reset);
        int base, k, stb_bad;
        s_na_en = 1'b1; s_na_adr = dead_adr; s_dmax = 0; s_spur = 1'b0;
        @(negedge clk);
        base = q_adr.size();
        cmd_valid = 1'b1; cmd_opa = 32'h1111_2222; cmd_opb = 32'h3333_4444;
        cmd_opv = 13'h100; cmd_frm = 3'h1;
        k = 0;
        while (!cmd_ready && k < 300) begin @(negedge clk); k++; end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        if (do_reset) begin
            check_val("rst_pre_stb", 32'(wbm_stb_o), 32'd1);
            rst_l = 1'b0;
            @(posedge clk); #1;
            check_val("rst_cyc_stb", {30'h0, wbm_cyc_o, wbm_stb_o}, 32'h0);
            check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            @(negedge clk);
            rst_l = 1'b1;
            s_na_en = 1'b0;
            @(negedge clk);
            check_val("rst_cmd_ready", 32'(cmd_ready), 32'd1);
            check_val("rst_no_stb", 32'(wbm_stb_o), 32'd0);
        end else begin
            k = 0;
            while (!rsp_valid && k < 400) begin @(negedge clk); k++; end
            check_val("to_rsp_seen", 32'(rsp_valid), 32'd1);
            check_val("to_err", 32'(rsp_err), 32'd1);
            check_val("to_result", rsp_result, 32'h0);
            check_val("to_exc", 32'(rsp_exc), 32'h0);
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            stb_bad = 0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                if (wbm_stb_o) stb_bad++;
            end
            #1;
            check_val("to_no_more_stb", 32'(stb_bad), 32'd0);
            check_val("to_stb_len", 32'(s_last_run), 32'(c_to));
            check_val("to_xfers", 32'(q_adr.size() - base), 32'd1);
            s_na_en = 1'b0;
        end
    endtask

    initial begin
        logic [12:0] opv;
        logic [10:0] vin;
        repeat (3) @(negedge clk);
        check_val("rst_wb_ctl", {25'h0, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}, 32'h0);
        check_val("rst_wb_adr", wbm_adr_o, 32'h0);
        check_val("rst_wb_dat", wbm_dat_o, 32'h0);
        check_val("rst_rsp", {25'h0, rsp_valid, rsp_err, rsp_exc}, 32'h0);
        check_val("rst_result", rsp_result, 32'h0);
        check_val("rst_ready", 32'(cmd_ready), 32'd1);
        rst_l = 1'b1;

        run_cmd(32'h3F80_0000, 32'h4000_0000, 32'h0, 13'h100, 3'h0, 32'h4040_0000, 32'h0, 0, 1'b0, 0);
        run_cmd(32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 13'h400, 3'h2, 32'h40E0_0000, 32'h1, 0, 1'b0, 0);
        run_cmd(32'h40C0_0000, 32'h4000_0000, 32'h0, 13'h800, 3'h0, 32'h4040_0000, 32'h0, 0, 1'b0, 0);
        run_cmd(32'h4080_0000, 32'h0, 32'h0, 13'h1000, 3'h3, 32'h4000_0000, 32'h10, 0, 1'b1, 0);
        run_cmd(32'h1, 32'h2, 32'h3, 13'h000, 3'h0, 32'hDEAD_BEEF, 32'h1F, 0, 1'b0, 0);
        run_cmd(32'h1, 32'h2, 32'h3, 13'h0C0, 3'h0, 32'hDEAD_BEEF, 32'h1F, 0, 1'b0, 0);
        run_cmd(32'hAAAA_5555, 32'h5555_AAAA, 32'h0, 13'h101, 3'h4, 32'h1234_5678, 32'hFFFF_FFE5, 1, 1'b1, 10);
        run_stall(c_base + 32'h04, 1'b0);

        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 7) == 0) begin
                vin = 11'($urandom);
                if ($countones(vin) == 1) vin = vin | 11'h003;
            end else begin
                vin = 11'd1 << $urandom_range(0, 10);
            end
            opv = {vin, 2'($urandom_range(0, 3))};
            run_cmd($urandom, $urandom, $urandom, opv, 3'($urandom_range(0, 7)),
                    $urandom, $urandom, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)));
        end

        run_stall(c_base, 1'b1);
        run_cmd(32'h3F80_0000, 32'h4000_0000, 32'h0, 13'h100, 3'h0, 32'h4040_0000, 32'h0, 0, 1'b0, 0);

        check_val("no_back_to_back", 32'(s_b2b), 32'd0);
        check_val("sel_all_bytes", 32'(s_sel_bad), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
